// File: rtl/sync_memory.sv
// ----------------------------------------------------------------------------
// sync_memory
//   Synchronous single-port RAM behind a valid/ready request interface.
//   Writes use per-lane enables. Reads come back through a pipeline of
//   READ_LATENCY registers. An optional clear sequence after reset writes
//   zero to every word before requests are accepted.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_req_valid  request present
//   o_req_ready  request accepted when valid & ready at the edge
//   i_req_we     1 = write, 0 = read
//   i_req_addr   word address (modulo depth)
//   i_req_wdata  write data
//   i_req_be     lane write enables, bit k covers lane k
//   o_rd_valid   o_rd_data valid this cycle
//   o_rd_data    read data, held while o_rd_valid = 0
//   o_busy       clear sequence in progress
// ----------------------------------------------------------------------------
module sync_memory #(
    parameter int unsigned ADDRESS_SIZE   = 8,
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned LANES          = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDRESS_SIZE-1:0] i_req_addr,
    input  logic [WORD_SIZE-1:0]    i_req_wdata,
    input  logic [LANES-1:0]        i_req_be,
    output logic                    o_rd_valid,
    output logic [WORD_SIZE-1:0]    o_rd_data,
    output logic                    o_busy
);

    localparam int unsigned LANE_W = WORD_SIZE / LANES;
    localparam int unsigned DEPTH  = 2 ** ADDRESS_SIZE;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDRESS_SIZE-1:0] r_ptr;
    logic                    r_req_ready;
    logic                    r_busy;

    logic [WORD_SIZE-1:0]    r_mem [DEPTH];

    logic [READ_LATENCY-1:0] r_vld;
    logic [WORD_SIZE-1:0]    r_dat [READ_LATENCY];

    logic                    w_accept;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic                    w_clearing;
    logic [ADDRESS_SIZE-1:0] w_mem_addr;
    logic [WORD_SIZE-1:0]    w_mem_wdata;
    logic [LANES-1:0]        w_mem_lane_we;

    // Reset has priority over any request presented on the same edge.
    assign w_accept    = i_req_valid & r_req_ready & ~i_rst;
    assign w_wr_accept = w_accept & i_req_we;
    assign w_rd_accept = w_accept & ~i_req_we;
    assign w_clearing  = (r_state == ST_CLEAR) & ~i_rst;

    // Single write port shared by the clear sequence and accepted writes.
    always_comb begin
        w_mem_addr    = i_req_addr;
        w_mem_wdata   = i_req_wdata;
        w_mem_lane_we = '0;
        if (w_clearing) begin
            w_mem_addr    = r_ptr;
            w_mem_wdata   = '0;
            w_mem_lane_we = '1;
        end else if (w_wr_accept) begin
            w_mem_lane_we = i_req_be;
        end
    end

    // Control FSM: clear walk after reset, then serve requests.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_ptr       <= '0;
            r_busy      <= (CLEAR_ON_RESET != 0);
            r_req_ready <= (CLEAR_ON_RESET == 0);
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + ADDRESS_SIZE'(1);
                    // Last word written on this edge: open for requests.
                    if (&r_ptr) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Storage array; contents survive reset, the clear walk zeroes them.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            if (w_mem_lane_we[k]) begin
                r_mem[w_mem_addr][k*LANE_W +: LANE_W] <= w_mem_wdata[k*LANE_W +: LANE_W];
            end
        end
    end

    // Read pipeline; each stage only reloads data when fed a valid beat so
    // the last stage holds its value between responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_accept;
            if (w_rd_accept) begin
                r_dat[0] <= r_mem[i_req_addr];
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_busy      = r_busy;
    assign o_rd_valid  = r_vld[READ_LATENCY-1];
    assign o_rd_data   = r_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_sync_memory.sv
// ----------------------------------------------------------------------------
// tb_sync_memory
//   Directed bench for sync_memory (4-bit address, 8-bit word, 2 lanes,
//   read latency 2, clear on reset). A reference model tracks memory
//   contents, the clear countdown and outstanding reads; outputs are
//   compared against it every cycle, alongside literal expectations.
// ----------------------------------------------------------------------------
module tb_sync_memory;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned LN    = 2;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = DW / LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [LN-1:0] req_be;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    sync_memory #(
        .ADDRESS_SIZE  (AW),
        .WORD_SIZE     (DW),
        .LANES         (LN),
        .READ_LATENCY  (RL),
        .CLEAR_ON_RESET(1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .i_req_be   (req_be),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           m_q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clr    = 0;
    int            m_edge   = 0;
    logic          m_valid  = 1'b0;
    logic [DW-1:0] m_data   = '0;
    bit            m_started = 1'b0;

    always @(posedge clk) begin
        rd_t e;
        m_started = 1'b1;
        if (rst) begin
            m_clr = 0;
            m_q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        end else begin
            if (m_clr == int'(DEPTH) && req_valid) begin
                if (req_we) begin
                    for (int k = 0; k < int'(LN); k++)
                        if (req_be[k]) m_mem[req_addr][k*LW +: LW] = req_wdata[k*LW +: LW];
                end else begin
                    e.due  = m_edge + int'(RL) - 1;
                    e.data = m_mem[req_addr];
                    m_q.push_back(e);
                end
            end
            if (m_clr < int'(DEPTH)) m_clr++;
            m_valid = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == m_edge) begin
                m_valid = 1'b1;
                m_data  = m_q[0].data;
                void'(m_q.pop_front());
            end
        end
        m_edge++;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_started) begin
            chk("cyc_ready",    32'(req_ready), 32'(m_clr == int'(DEPTH)));
            chk("cyc_busy",     32'(busy),      32'(m_clr != int'(DEPTH)));
            chk("cyc_rd_valid", 32'(rd_valid),  32'(m_valid));
            chk("cyc_rd_data",  32'(rd_data),   32'(m_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clear(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n), 32'd16);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] b);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = b;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        int lat = 1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rd_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd2);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int            got_idx[$];
        logic [DW-1:0] got_dat[$];
        logic [DW-1:0] burst_exp [4];

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);

        // 1. reset values, clear duration, cleared contents
        chk("rst_busy",  32'(busy),      32'd1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rd_valid),  32'd0);
        chk("rst_data",  32'(rd_data),   32'd0);
        rst = 1'b0;
        wait_clear("clear1_cycles");
        do_read(4'd15, 8'h00, "rd15_cleared");

        // 2. full write then read-after-write
        do_write(4'd3, 8'hA5, 2'b11);
        do_read(4'd3, 8'hA5, "raw_a5");

        // 3. lane enables
        do_write(4'd3, 8'h3C, 2'b01);
        do_read(4'd3, 8'hAC, "lane0_ac");
        do_write(4'd3, 8'h55, 2'b00);
        do_read(4'd3, 8'hAC, "be0_ac");

        // 4. back-to-back reads
        do_write(4'd0, 8'h11, 2'b11);
        do_write(4'd1, 8'h22, 2'b11);
        do_write(4'd2, 8'h33, 2'b11);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (rd_valid) begin
                got_idx.push_back(i);
                got_dat.push_back(rd_data);
            end
            if (i < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        burst_exp[0] = 8'h11; burst_exp[1] = 8'h22; burst_exp[2] = 8'h33; burst_exp[3] = 8'hAC;
        chk("burst_count", 32'(got_idx.size()), 32'd4);
        if (got_idx.size() == 4) begin
            chk("burst_span", 32'(got_idx[3] - got_idx[0]), 32'd3);
            for (int i = 0; i < 4; i++) chk("burst_data", 32'(got_dat[i]), 32'(burst_exp[i]));
        end

        // 5. reset with reads in flight
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        @(negedge clk);
        req_addr = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(rd_valid),  32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd1);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        wait_clear("clear2_cycles");
        do_read(4'd3, 8'h00, "rd3_recleared");

        // 6. requests during clear are ignored
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'hFF; req_be = 2'b11;
        wait_clear("clear3_cycles");
        req_valid = 1'b0; req_we = 1'b0;
        do_read(4'd5, 8'h00, "rd5_ignored");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
